// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed common-anode seven-segment driver with a frame-synchronous shadow register.
// Optional anti-ghosting guard band at the start of each digit slot: define SEG7_GHOST_BLANK_EN.
module seg7_scan #(
  parameter int DIGITS        = 4,
  parameter int SCAN_DIV_BITS = 16
) (
  input  logic                  BJ_CLK,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   DATA_IN,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic [DIGITS-1:0]     BLANK_IN,
  input  logic                  LOAD,
  output logic [6:0]            SEG_OUT,
  output logic                  DP_OUT,
  output logic [DIGITS-1:0]     AN_OUT
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] prescaler;
  logic [IDX_W-1:0]         digit_idx;
  logic [SCAN_DIV_BITS-1:0] prescaler_nxt;
  logic [IDX_W-1:0]         digit_idx_nxt;
  logic                     tick;
  logic                     frame_tick;

  logic [4*DIGITS-1:0]      pend_data;
  logic [DIGITS-1:0]        pend_dp;
  logic [DIGITS-1:0]        pend_blank;
  logic [4*DIGITS-1:0]      shadow_data;
  logic [DIGITS-1:0]        shadow_dp;
  logic [DIGITS-1:0]        shadow_blank;

  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic                     cur_blank;
  logic                     guard;
  logic                     dark;
  logic [DIGITS-1:0]        an_onehot;
  logic [DIGITS-1:0]        an_nxt;
  logic [6:0]               seg_nxt;
  logic                     dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan timing: tick ends a digit slot, the wrap from the last digit ends a frame.
  always_comb begin
    tick          = &prescaler;
    frame_tick    = tick && (digit_idx == LAST_IDX);
    prescaler_nxt = prescaler + 1'b1;
    digit_idx_nxt = digit_idx;
    if (tick) begin
      digit_idx_nxt = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
    end
  end

  always_ff @(posedge BJ_CLK or posedge RESET) begin
    if (RESET) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else begin
      prescaler <= prescaler_nxt;
      digit_idx <= digit_idx_nxt;
    end
  end

  // A LOAD coinciding with the frame tick goes straight into the shadow so it is not delayed a frame.
  always_ff @(posedge BJ_CLK or posedge RESET) begin
    if (RESET) begin
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else begin
      if (LOAD) begin
        pend_data  <= DATA_IN;
        pend_dp    <= DP_IN;
        pend_blank <= BLANK_IN;
      end
      if (frame_tick) begin
        shadow_data  <= LOAD ? DATA_IN  : pend_data;
        shadow_dp    <= LOAD ? DP_IN    : pend_dp;
        shadow_blank <= LOAD ? BLANK_IN : pend_blank;
      end
    end
  end

`ifdef SEG7_GHOST_BLANK_EN
  assign guard = (prescaler[SCAN_DIV_BITS-1 -: 3] == 3'b000);
`else
  assign guard = 1'b0;
`endif

  always_comb begin
    cur_nib   = shadow_data[{digit_idx, 2'b00} +: 4];
    cur_dp    = shadow_dp[digit_idx];
    cur_blank = shadow_blank[digit_idx];
    dark      = cur_blank | guard;
    an_onehot = '0;
    an_onehot[digit_idx] = 1'b1;
    an_nxt    = dark ? '1    : ~an_onehot;
    seg_nxt   = dark ? 7'h7F : hex_to_seg(cur_nib);
    dp_nxt    = dark ? 1'b1  : ~cur_dp;
  end

  // Registered drive keeps the pad lines glitch-free; they trail the index by one clock.
  always_ff @(posedge BJ_CLK or posedge RESET) begin
    if (RESET) begin
      AN_OUT  <= '1;
      SEG_OUT <= 7'h7F;
      DP_OUT  <= 1'b1;
    end else begin
      AN_OUT  <= an_nxt;
      SEG_OUT <= seg_nxt;
      DP_OUT  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scoreboard bench for seg7_scan with DIGITS=4, SCAN_DIV_BITS=4.
// Honours SEG7_GHOST_BLANK_EN when the design is built with it.
module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int SDB    = 4;
`ifdef SEG7_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic        BJ_CLK = 1'b0;
  logic        RESET;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic [3:0]  BLANK_IN;
  logic        LOAD;
  logic [6:0]  SEG_OUT;
  logic        DP_OUT;
  logic [3:0]  AN_OUT;

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV_BITS(SDB)) dut (
    .BJ_CLK  (BJ_CLK),
    .RESET   (RESET),
    .DATA_IN (DATA_IN),
    .DP_IN   (DP_IN),
    .BLANK_IN(BLANK_IN),
    .LOAD    (LOAD),
    .SEG_OUT (SEG_OUT),
    .DP_OUT  (DP_OUT),
    .AN_OUT  (AN_OUT)
  );

  always #5 BJ_CLK = ~BJ_CLK;

  int          n_vec;
  int          n_err;
  int          m_cnt;
  logic [15:0] m_pd, m_sd;
  logic [3:0]  m_pdp, m_sdp, m_pbl, m_sbl;
  logic [11:0] sb_q[$];
  int          dark_n;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Output expected after the edge that ends clock number cnt (counted from reset release).
  function automatic logic [11:0] ref_out(input int cnt);
    int         pre, idx;
    logic [3:0] an;
    logic [3:0] nib;
    pre = cnt % 16;
    idx = (cnt / 16) % 4;
    if (m_sbl[idx] || (GHOST && pre < 2)) return 12'hFFF;
    an  = ~(4'b0001 << idx);
    nib = m_sd[idx*4 +: 4];
    return {an, ref_seg(nib), ~m_sdp[idx]};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = {AN_OUT, SEG_OUT, DP_OUT};
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s clk=%0d got an/seg/dp=%h expected=%h", tag, m_cnt, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_pd = '0;  m_pdp = '0;  m_pbl = '0;
    m_sd = '0;  m_sdp = '0;  m_sbl = '0;
  endtask

  task automatic step();
    logic [11:0] e;
    sb_q.push_back(ref_out(m_cnt));
    if (LOAD) begin
      m_pd = DATA_IN;  m_pdp = DP_IN;  m_pbl = BLANK_IN;
    end
    if (m_cnt % 64 == 63) begin
      m_sd = m_pd;  m_sdp = m_pdp;  m_sbl = m_pbl;
    end
    @(posedge BJ_CLK);
    #1;
    m_cnt++;
    e = sb_q.pop_front();
    chk("scan", e);
  endtask

  task automatic run_to(input int target);
    while (m_cnt < target) step();
  endtask

  initial begin
    n_vec = 0;  n_err = 0;
    RESET = 1'b1;  LOAD = 1'b0;
    DATA_IN = '0;  DP_IN = '0;  BLANK_IN = '0;
    model_reset();
    repeat (2) @(posedge BJ_CLK);
    #1;
    chk("reset_dark", 12'hFFF);
    RESET = 1'b0;

    step();
    chk("first_clk", GHOST ? 12'hFFF : {4'b1110, 7'h40, 1'b1});
    run_to(21);
    chk("slot1", {4'b1101, 7'h40, 1'b1});

    // Mid-frame load, then scribble the live inputs to prove pending held them.
    DATA_IN = 16'hA5F1;  DP_IN = 4'b0100;  LOAD = 1'b1;
    step();
    LOAD = 1'b0;  DATA_IN = 16'h3C3C;  DP_IN = 4'b1111;
    run_to(53);
    chk("no_early", {4'b0111, 7'h40, 1'b1});
    run_to(69);
    chk("d0_1", {4'b1110, 7'h79, 1'b1});
    run_to(85);
    chk("d1_F", {4'b1101, 7'h0E, 1'b1});
    run_to(101);
    chk("d2_5dp", {4'b1011, 7'h12, 1'b0});
    run_to(117);
    chk("d3_A", {4'b0111, 7'h08, 1'b1});

    // Load on the frame-boundary clock itself.
    run_to(127);
    DATA_IN = 16'h8888;  DP_IN = 4'b0000;  LOAD = 1'b1;
    step();
    LOAD = 1'b0;  DATA_IN = 16'h0000;
    run_to(129);
    chk("fb_load", GHOST ? 12'hFFF : {4'b1110, 7'h00, 1'b1});
    run_to(197);
    chk("fb_pend", {4'b1110, 7'h00, 1'b1});

    run_to(208);
    dark_n = 0;
    repeat (16) begin
      step();
      if (AN_OUT === 4'hF) dark_n++;
    end
    n_vec++;
    assert (dark_n == (GHOST ? 2 : 0)) else begin
      n_err++;
      $error("FAIL guard_band dark clocks got=%0d expected=%0d", dark_n, GHOST ? 2 : 0);
    end

    DATA_IN = 16'h1234;  DP_IN = 4'b0000;  BLANK_IN = 4'b1010;  LOAD = 1'b1;
    step();
    LOAD = 1'b0;  DATA_IN = '0;  BLANK_IN = '0;
    run_to(261);
    chk("blk_d0", {4'b1110, 7'h19, 1'b1});
    run_to(277);
    chk("blk_d1", 12'hFFF);
    run_to(293);
    chk("blk_d2", {4'b1011, 7'h24, 1'b1});
    run_to(309);
    chk("blk_d3", 12'hFFF);

    // Asynchronous reset in the middle of slot 2.
    run_to(359);
    RESET = 1'b1;
    #1;
    chk("async_rst", 12'hFFF);
    @(posedge BJ_CLK);
    #1;
    chk("rst_hold", 12'hFFF);
    RESET = 1'b0;
    model_reset();
    step();
    chk("rst_first", GHOST ? 12'hFFF : {4'b1110, 7'h40, 1'b1});
    run_to(37);
    chk("rst_d2", {4'b1011, 7'h40, 1'b1});
    run_to(69);
    chk("rst_pend", {4'b1110, 7'h40, 1'b1});

    // Back-to-back random loads: only the last one should reach the display.
    repeat (3) begin
      DATA_IN = 16'($urandom);  DP_IN = 4'($urandom_range(0, 15));  LOAD = 1'b1;
      step();
    end
    LOAD = 1'b0;  DATA_IN = 16'hFFFF;  DP_IN = '0;
    run_to(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
